// File: rtl/rom_fetch_seq_pkg.sv
// Shared constants and types for the primitive ROM fetch sequencer.
// A primitive is WORDS_PER_PRIM ROM words packed with word k at bits [DATA_W*k +: DATA_W].
package z_buffer_pkg;

  localparam int ADDR_W         = 4;
  localparam int DATA_W         = 24;
  localparam int WORDS_PER_PRIM = 4;
  localparam int NUM_PRIM       = 4;
  localparam int ROM_DEPTH      = 2 ** ADDR_W;

  localparam int WCNT_W = (WORDS_PER_PRIM > 1) ? $clog2(WORDS_PER_PRIM) : 1;
  localparam int PIDX_W = (NUM_PRIM > 1) ? $clog2(NUM_PRIM) : 1;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_PRIM - 1);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(NUM_PRIM - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} fetch_state_t;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    word_t [WORDS_PER_PRIM-1:0] w;
  } prim_t;

endpackage

// File: rtl/rom_fetch_seq_if.sv
// ROM read port plus the primitive valid/ready stream towards the rasteriser.
// master = sequencer side, slave = ROM/consumer side.
interface rom_fetch_seq_if;
  import z_buffer_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  word_t             rom_data;
  logic              prim_valid;
  logic              prim_ready;
  prim_t             prim_data;
  logic [PIDX_W-1:0] prim_index;
  logic              prim_last;

  modport master (
    output rom_addr,
    input  rom_data,
    output prim_valid,
    input  prim_ready,
    output prim_data,
    output prim_index,
    output prim_last
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  prim_valid,
    output prim_ready,
    input  prim_data,
    input  prim_index,
    input  prim_last
  );

endinterface

// File: rtl/rom_fetch_seq_out.sv
// Primitive holding register with the downstream valid/ready handshake.
// Slots are overwritten one per write; contents persist across primitives until rewritten.
module prim_out_reg
  import z_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [WCNT_W-1:0] wr_slot_i,
  input  word_t             wr_word_i,
  input  logic              present_i,
  input  logic [PIDX_W-1:0] index_i,
  input  logic              ready_i,
  output logic              valid_o,
  output prim_t             data_o,
  output logic [PIDX_W-1:0] index_o,
  output logic              last_o,
  output logic              hs_o
);

  prim_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (wr_en_i) begin
      data_d.w[wr_slot_i] = wr_word_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Index and last are only meaningful alongside valid, so they read 0 otherwise.
  assign valid_o = present_i;
  assign data_o  = data_q;
  assign index_o = present_i ? index_i : '0;
  assign last_o  = present_i && (index_i == PIDX_LAST);
  assign hs_o    = present_i && ready_i;

endmodule

// File: rtl/rom_fetch_seq.sv
// Walks the external ROM on start and streams NUM_PRIM primitives of WORDS_PER_PRIM words each.
// First primitive valid WORDS_PER_PRIM cycles after start; holds while prim_ready is low.
module rom_fetch_seq
  import z_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  rom_fetch_seq_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [PIDX_W-1:0] pcnt_q, pcnt_d;
  logic              fetch_we;
  logic              presenting;
  logic              prim_hs;

  assign presenting = (state_q == PRESENT);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    pcnt_d   = pcnt_q;
    fetch_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = FETCH;
          wcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      FETCH: begin
        fetch_we = 1'b1;
        addr_d   = addr_q + 1'b1;
        wcnt_d   = wcnt_q + 1'b1;
        if (wcnt_q == WCNT_LAST) begin
          wcnt_d  = '0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (prim_hs) begin
          if (pcnt_q == PIDX_LAST) begin
            state_d = FINISH;
            addr_d  = '0;
          end else begin
            pcnt_d  = pcnt_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      FINISH: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign busy         = (state_q == FETCH) || (state_q == PRESENT);
  assign done         = (state_q == FINISH);
  assign bus.rom_addr = addr_q;

  prim_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fetch_we),
    .wr_slot_i (wcnt_q),
    .wr_word_i (bus.rom_data),
    .present_i (presenting),
    .index_i   (pcnt_q),
    .ready_i   (bus.prim_ready),
    .valid_o   (bus.prim_valid),
    .data_o    (bus.prim_data),
    .index_o   (bus.prim_index),
    .last_o    (bus.prim_last),
    .hs_o      (prim_hs)
  );

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Bench for rom_fetch_seq: ROM returns 24'h111111*addr; frames checked cycle by cycle against spec timing.
module tb_rom_fetch_seq;
  import z_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  rom_fetch_seq_if bus ();

  rom_fetch_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = DATA_W'(32'h111111 * {28'd0, bus.rom_addr});

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (!rst && bus.prim_valid && bus.prim_ready) hs_cnt <= hs_cnt + 1;
    if (!rst && done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Primitive p holds ROM words at addresses p*W .. p*W+W-1 (mod depth).
  function automatic prim_t exp_prim(int p);
    prim_t r;
    for (int k = 0; k < WORDS_PER_PRIM; k++) begin
      r.w[k] = DATA_W'(32'h111111 * ((p * WORDS_PER_PRIM + k) % ROM_DEPTH));
    end
    return r;
  endfunction

  // One frame: start in the current cycle, then W fetch cycles and a present phase per primitive.
  // stall1: ready-low cycles on primitive 1; rnd: random ready/stalls; poke: random start while busy;
  // abort_at: assert rst during PRESENT of that primitive (-1 = never).
  task automatic run_frame(input int stall1, input bit rnd, input bit poke, input int abort_at);
    int hs0, dn0, stall;
    hs0 = hs_cnt;
    dn0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < NUM_PRIM; p++) begin
      for (int c = 0; c < WORDS_PER_PRIM; c++) begin
        if (rnd) bus.prim_ready = 1'($urandom_range(0, 1));
        if (poke) start = 1'($urandom_range(0, 1));
        n_checks++;
        if (bus.prim_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_ctrl p=%0d c=%0d: valid=%b busy=%b done=%b want 0 1 0", p, c, bus.prim_valid, busy, done);
        end
        n_checks++;
        if (bus.rom_addr !== ADDR_W'((p * WORDS_PER_PRIM + c) % ROM_DEPTH)) begin
          n_fail++;
          $display("FAIL fetch_addr p=%0d c=%0d: got %0d want %0d", p, c, bus.rom_addr, (p * WORDS_PER_PRIM + c) % ROM_DEPTH);
        end
        tick();
      end
      if (p == abort_at) begin
        start = 1'b0;
        bus.prim_ready = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.prim_valid !== 1'b0 || bus.prim_last !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_ctrl: busy=%b done=%b valid=%b last=%b want all 0", busy, done, bus.prim_valid, bus.prim_last);
        end
        n_checks++;
        if (bus.rom_addr !== '0 || bus.prim_index !== '0 || bus.prim_data !== '0) begin
          n_fail++;
          $display("FAIL abort_bus: addr=%h idx=%h data=%h want 0", bus.rom_addr, bus.prim_index, bus.prim_data);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.prim_valid !== 1'b0 || busy !== 1'b0 || done_cnt != dn0 || hs_cnt != hs0 + abort_at) begin
          n_fail++;
          $display("FAIL abort_idle: valid=%b busy=%b dones=%0d hs=%0d want 0 0 %0d %0d", bus.prim_valid, busy, done_cnt - dn0, hs_cnt - hs0, 0, abort_at);
        end
        return;
      end
      stall = (p == 1) ? stall1 : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s <= stall; s++) begin
        bus.prim_ready = (s == stall);
        if (poke) start = 1'($urandom_range(0, 1));
        n_checks++;
        if (bus.prim_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL present_ctrl p=%0d s=%0d: valid=%b busy=%b done=%b want 1 1 0", p, s, bus.prim_valid, busy, done);
        end
        n_checks++;
        if (bus.prim_data !== exp_prim(p)) begin
          n_fail++;
          $display("FAIL prim_data p=%0d s=%0d: got %h want %h", p, s, bus.prim_data, exp_prim(p));
        end
        n_checks++;
        if (bus.prim_index !== PIDX_W'(p) || bus.prim_last !== (p == NUM_PRIM - 1)) begin
          n_fail++;
          $display("FAIL prim_idx p=%0d s=%0d: idx=%0d last=%b want %0d %b", p, s, bus.prim_index, bus.prim_last, p, (p == NUM_PRIM - 1));
        end
        n_checks++;
        if (bus.rom_addr !== ADDR_W'(((p + 1) * WORDS_PER_PRIM) % ROM_DEPTH)) begin
          n_fail++;
          $display("FAIL present_addr p=%0d s=%0d: got %0d want %0d", p, s, bus.rom_addr, ((p + 1) * WORDS_PER_PRIM) % ROM_DEPTH);
        end
        tick();
      end
    end
    if (poke) start = 1'b1;
    if (rnd) bus.prim_ready = 1'($urandom_range(0, 1));
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.prim_valid !== 1'b0 || bus.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL finish: done=%b busy=%b valid=%b addr=%0d want 1 0 0 0", done, busy, bus.prim_valid, bus.rom_addr);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.prim_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: done=%b busy=%b valid=%b want 0 0 0", done, busy, bus.prim_valid);
    end
    n_checks++;
    if (hs_cnt - hs0 != NUM_PRIM || done_cnt - dn0 != 1) begin
      n_fail++;
      $display("FAIL frame_counts: hs=%0d dones=%0d want %0d 1", hs_cnt - hs0, done_cnt - dn0, NUM_PRIM);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.prim_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.prim_valid !== 1'b0 || bus.prim_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b last=%b want all 0", busy, done, bus.prim_valid, bus.prim_last);
    end
    n_checks++;
    if (bus.rom_addr !== '0 || bus.prim_index !== '0 || bus.prim_data !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h idx=%h data=%h want 0", bus.rom_addr, bus.prim_index, bus.prim_data);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || bus.prim_valid !== 1'b0 || bus.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b addr=%0d want 0 0 0", busy, bus.prim_valid, bus.rom_addr);
    end
  endtask

  task automatic test_single_frame();
    bus.prim_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0, -1);
    tick();
  endtask

  task automatic test_backpressure();
    bus.prim_ready = 1'b1;
    run_frame(7, 1'b0, 1'b0, -1);
    tick();
  endtask

  task automatic test_start_ignored();
    bus.prim_ready = 1'b1;
    run_frame(2, 1'b1, 1'b1, -1);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.prim_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0, 2);
    bus.prim_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    bus.prim_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_ready_idle();
    int hs0;
    hs0 = hs_cnt;
    bus.prim_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (bus.prim_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hs_cnt != hs0) begin
        n_fail++;
        $display("FAIL ready_idle i=%0d: valid=%b busy=%b done=%b hs=%0d want 0 0 0 0", i, bus.prim_valid, busy, done, hs_cnt - hs0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_frame(int'($urandom_range(0, 7)), 1'b1, 1'b1, -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.prim_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_ready_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
